seq_pattern_tx: RTL
===================

// Module: seq_pattern_tx
// PURPOSE
//  Serial pattern transmitter: accepts a parallel word on a start strobe and drives it
//  out one bit per clock, MSB-first, behind a fixed preamble.
//  Drives the single-bit serial input 'x' of the downstream sequence-detector FSMs.
//  Preamble default 3'b101 is the marker those detectors recognise; then payload, then idle gap.
// PARAMETERS
//  DATA_W    8       payload width in bits (>=1)
//  PRE_W     3       preamble width in bits (>=1)
//  PREAMBLE  3'b101  preamble pattern, sent MSB-first
//  GAP       2       idle cycles after each frame before a new start is accepted (>=0)
// PORTS
//  clk    in   1       single clock, all logic on posedge
//  reset  in   1       synchronous, active-high
//  start  in   1       request to send a frame; sampled only in IDLE
//  data   in   DATA_W  payload, captured on the edge that accepts start
//  x      out  1       serial bit stream; 0 when not valid
//  valid  out  1       high on every cycle x carries a preamble/payload/parity bit
//  busy   out  1       high from the cycle after acceptance until the block returns to IDLE
//  done   out  1       one-cycle pulse the cycle after the last frame bit
// BEHAVIOUR
//  - All outputs registered. Reset: x=0, valid=0, busy=0, done=0, state=IDLE, shift reg and counters=0.
//  - States: IDLE -> PRE -> DATA -> [PAR] -> GAP -> IDLE.
//  - IDLE: start=1 at edge E0 captures data and enters PRE. Cycle after E0: valid=1, busy=1, x=PREAMBLE[PRE_W-1].
//  - PRE: PRE_W cycles, x = PREAMBLE bits MSB..LSB. DATA: DATA_W cycles, x = data MSB..LSB.
//  - Frame length F = PRE_W + DATA_W (+1 with parity). Bit k (0-based) appears on cycle k+1 after E0.
//  - After the last bit: valid=0, x=0, done=1 for exactly one cycle (cycle F+1). This is the first GAP cycle.
//  - If GAP=0, that cycle is IDLE with busy=0.
//  - GAP: GAP cycles with busy=1, valid=0, x=0. Then IDLE with busy=0. start in the first IDLE cycle is accepted.
//  - start=1 while busy is ignored and not queued. start held high gives back-to-back frames:
//    F bits, then GAP idle cycles, then one IDLE acceptance cycle.
//  - Changing data while busy has no effect on the frame in flight.
//  - reset=1 mid-frame: at that edge, return to reset values. No done pulse. Partial frame abandoned.
//  - reset and start in the same cycle: reset wins. start is not accepted.
//  - Counters are sized ceil(log2(max(PRE_W, DATA_W, GAP)+1)) and never wrap within a state.
// CONFIGURATION
//  SEQ_TX_PARITY_EN defined:
//    - PAR state after DATA: one extra bit with valid=1, x = even parity (XOR) of the captured payload.
//    - F grows by 1. done is delayed by 1 cycle.
//  SEQ_TX_PARITY_EN undefined:
//    - no PAR state; DATA goes directly to done/GAP. Port list unchanged.
// TESTING (DATA_W=8, PRE_W=3, PREAMBLE=3'b101, GAP=2 unless stated)
//  1. reset 2 cycles, start=0 -> x=0, valid=0, busy=0, done=0 throughout.
//  2. start pulse, data=8'hA5, no parity -> cycles 1..11 x=1,0,1,1,0,1,0,0,1,0,1, valid=1.
//     Cycle 12: done=1, valid=0. Cycles 13: busy=1. Cycle 14: busy=0.
//  3. SEQ_TX_PARITY_EN, data=8'hA5 -> cycle 12 x=0, valid=1; done on cycle 13.
//     SEQ_TX_PARITY_EN, data=8'h07 -> parity bit x=1.
//  4. start held high, data=8'hFF then 8'h00 -> first frame all payload 1s.
//     Second valid run begins exactly GAP+2 cycles after the first ends, payload all 0s.
//  5. start pulsed at cycle 5 of a frame, data changed -> ignored; frame bits unchanged; single done.
//  6. reset asserted at cycle 6 of a frame -> next cycle all outputs 0, no done.
//     start one cycle after reset deasserts gives a clean full frame.

Source files
------------

// File: rtl/seq_pattern_tx_if.sv
// Handshake/serial bundle for seq_pattern_tx: frame request in, serial stream and status out.
interface seq_pattern_tx_if #(
    parameter int DATA_W = 8
);
    logic              start;
    logic [DATA_W-1:0] data;
    logic              x;
    logic              valid;
    logic              busy;
    logic              done;

    modport master (
        output start,
        output data,
        input  x,
        input  valid,
        input  busy,
        input  done
    );

    modport slave (
        input  start,
        input  data,
        output x,
        output valid,
        output busy,
        output done
    );
endinterface

// File: rtl/seq_pattern_tx.sv
// Serial pattern transmitter: preamble then payload MSB-first, optional even-parity bit
// when SEQ_TX_PARITY_EN is defined, followed by an idle gap before the next frame.
module seq_pattern_tx #(
    parameter int               DATA_W   = 8,
    parameter int               PRE_W    = 3,
    parameter logic [PRE_W-1:0] PREAMBLE = 3'b101,
    parameter int               GAP      = 2
) (
    input  logic           clk,
    input  logic           reset,
    seq_pattern_tx_if.slave tx
);
    localparam int MAX_PD = (PRE_W > DATA_W) ? PRE_W : DATA_W;
    localparam int MAX_N  = (MAX_PD > GAP) ? MAX_PD : GAP;
    localparam int CNT_W  = (MAX_N < 1) ? 1 : $clog2(MAX_N + 1);

    localparam logic [CNT_W-1:0] PRE_LAST  = CNT_W'(PRE_W - 1);
    localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_W - 1);
    localparam logic [CNT_W-1:0] GAP_LAST  = (GAP > 0) ? CNT_W'(GAP - 1) : '0;

    typedef enum logic [2:0] {
        S_IDLE,
        S_PRE,
        S_DATA,
        S_PAR,
        S_GAP
    } state_t;

    state_t             state_reg, state_next;
    logic [CNT_W-1:0]   cnt_reg, cnt_next;
    logic [PRE_W-1:0]   pre_sr_reg, pre_sr_next;
    logic [DATA_W-1:0]  data_sr_reg, data_sr_next;
    logic               x_reg, x_next;
    logic               valid_reg, valid_next;
    logic               busy_reg, busy_next;
    logic               done_reg, done_next;
    logic               par_bit;

`ifdef SEQ_TX_PARITY_EN
    logic [DATA_W:0]    par_chain;
    logic               par_reg, par_next;

    // Even parity of the payload as an XOR chain over the incoming word.
    assign par_chain[0] = 1'b0;
    genvar gi;
    generate
        for (gi = 0; gi < DATA_W; gi++) begin : g_par
            assign par_chain[gi+1] = par_chain[gi] ^ tx.data[gi];
        end
    endgenerate

    assign par_bit = par_next;
`else
    assign par_bit = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg   <= S_IDLE;
            cnt_reg     <= '0;
            pre_sr_reg  <= '0;
            data_sr_reg <= '0;
            x_reg       <= 1'b0;
            valid_reg   <= 1'b0;
            busy_reg    <= 1'b0;
            done_reg    <= 1'b0;
`ifdef SEQ_TX_PARITY_EN
            par_reg     <= 1'b0;
`endif
        end else begin
            state_reg   <= state_next;
            cnt_reg     <= cnt_next;
            pre_sr_reg  <= pre_sr_next;
            data_sr_reg <= data_sr_next;
            x_reg       <= x_next;
            valid_reg   <= valid_next;
            busy_reg    <= busy_next;
            done_reg    <= done_next;
`ifdef SEQ_TX_PARITY_EN
            par_reg     <= par_next;
`endif
        end
    end

    always_comb begin
        state_next   = state_reg;
        cnt_next     = cnt_reg;
        pre_sr_next  = pre_sr_reg;
        data_sr_next = data_sr_reg;
        done_next    = 1'b0;
`ifdef SEQ_TX_PARITY_EN
        par_next     = par_reg;
`endif

        case (state_reg)
            S_IDLE: begin
                if (tx.start) begin
                    state_next   = S_PRE;
                    cnt_next     = '0;
                    pre_sr_next  = PREAMBLE;
                    data_sr_next = tx.data;
`ifdef SEQ_TX_PARITY_EN
                    par_next     = par_chain[DATA_W];
`endif
                end
            end

            S_PRE: begin
                if (cnt_reg == PRE_LAST) begin
                    state_next = S_DATA;
                    cnt_next   = '0;
                end else begin
                    cnt_next    = cnt_reg + CNT_W'(1);
                    pre_sr_next = pre_sr_reg << 1;
                end
            end

            S_DATA: begin
                if (cnt_reg == DATA_LAST) begin
                    cnt_next = '0;
`ifdef SEQ_TX_PARITY_EN
                    state_next = S_PAR;
`else
                    done_next  = 1'b1;
                    state_next = (GAP > 0) ? S_GAP : S_IDLE;
`endif
                end else begin
                    cnt_next     = cnt_reg + CNT_W'(1);
                    data_sr_next = data_sr_reg << 1;
                end
            end

`ifdef SEQ_TX_PARITY_EN
            S_PAR: begin
                cnt_next   = '0;
                done_next  = 1'b1;
                state_next = (GAP > 0) ? S_GAP : S_IDLE;
            end
`endif

            S_GAP: begin
                if (cnt_reg == GAP_LAST) begin
                    state_next = S_IDLE;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt_reg + CNT_W'(1);
                end
            end

            default: begin
                state_next = S_IDLE;
                cnt_next   = '0;
            end
        endcase
    end

    // Outputs are registered from the state being entered, so the first preamble
    // bit is already on x in the cycle right after start is accepted.
    always_comb begin
        x_next     = 1'b0;
        valid_next = 1'b0;
        busy_next  = (state_next != S_IDLE);
        case (state_next)
            S_PRE: begin
                x_next     = pre_sr_next[PRE_W-1];
                valid_next = 1'b1;
            end
            S_DATA: begin
                x_next     = data_sr_next[DATA_W-1];
                valid_next = 1'b1;
            end
            S_PAR: begin
                x_next     = par_bit;
                valid_next = 1'b1;
            end
            default: begin
                x_next     = 1'b0;
                valid_next = 1'b0;
            end
        endcase
    end

    assign tx.x     = x_reg;
    assign tx.valid = valid_reg;
    assign tx.busy  = busy_reg;
    assign tx.done  = done_reg;
endmodule
